rca_accumulator: RTL and testbench

//  Sequential front/back stage wrapped around the RCA20 adder. Accepts a stream of
//  20-bit two's-complement samples over a valid/ready handshake.

---
 rtl/rca_pkg.sv | 12 +
 rtl/rca20.sv | 25 ++
 rtl/rca_accumulator.sv | 85 ++++++++
 tb/tb_rca_accumulator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the RCA20 adder and the accumulator built around it.
package rca_pkg;

  localparam int RCA_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rca20.sv
// RCA20: 20-bit ripple-carry adder, purely combinational, with signed-overflow flag.
module rca20
  import rca_pkg::*;
(
  input  logic [RCA_WIDTH-1:0] a,
  input  logic [RCA_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [RCA_WIDTH-1:0] sum,
  output logic                 ovf
);

  logic [RCA_WIDTH:0] carry;

  assign carry[0] = cin;

  // Full-adder chain, carry rippling from bit 0 upward.
  for (genvar i = 0; i < RCA_WIDTH; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  // Signed overflow: operands share a sign that the result does not.
  assign ovf = (a[RCA_WIDTH-1] == b[RCA_WIDTH-1]) && (sum[RCA_WIDTH-1] != a[RCA_WIDTH-1]);

endmodule

// File: rtl/rca_accumulator.sv
// Accumulates a programmed number of signed samples through RCA20, with a sticky
// signed-overflow flag and a one-cycle done pulse when the run completes.
module rca_accumulator
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        len,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] acc,
  output logic                    ovf,
  output logic                    busy,
  output logic                    done
);

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt;
  logic signed [WIDTH-1:0] sum_p0;
  logic                    add_ovf_p0;
  logic                    accept;

  assign accept = in_valid && in_ready;

  // Stage p0: combinational add of the current total and the offered sample.
  rca20 u_rca20 (
    .a   (acc),
    .b   (in_data),
    .cin (1'b0),
    .sum (sum_p0),
    .ovf (add_ovf_p0)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = (len != '0) ? ACCUM : DONE;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && cnt == CNT_W'(1)) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Total, sticky overflow and remaining-sample counter; cleared on each new run.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (state == IDLE && start) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= len;
    end else if (accept) begin
      acc <= sum_p0;
      ovf <= ovf | add_ovf_p0;
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rca_accumulator.sv
// Self-checking bench for rca_accumulator: directed scenarios plus random traffic,
// compared every cycle against a behavioural integer model.
module tb_rca_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [19:0] in_data = '0;
  logic        in_ready;
  logic [19:0] acc;
  logic        ovf;
  logic        busy;
  logic        done;

  int nchecks = 0;
  int nerrors = 0;

  rca_accumulator #(.WIDTH(20), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .acc      (acc),
    .ovf      (ovf),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a run is "remaining samples still owed"; totals are plain integers.
  logic [19:0] m_acc  = '0;
  logic        m_ovf  = 1'b0;
  bit          m_run  = 1'b0;
  bit          m_done = 1'b0;
  int          m_rem  = 0;
  bit          seen_rst = 1'b0;

  always @(posedge clk) begin
    int s;
    if (rst) begin
      seen_rst = 1'b1;
      m_acc = '0; m_ovf = 1'b0; m_run = 1'b0; m_done = 1'b0; m_rem = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_run) begin
      if (start) begin
        m_acc = '0;
        m_ovf = 1'b0;
        if (len == 8'd0) m_done = 1'b1;
        else begin
          m_run = 1'b1;
          m_rem = int'(len);
        end
      end
    end else if (in_valid) begin
      s = int'($signed(m_acc)) + int'($signed(in_data));
      if (s > 524287 || s < -524288) m_ovf = 1'b1;
      m_acc = s[19:0];
      m_rem--;
      if (m_rem == 0) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end
  end

  // Compare DUT against the model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (seen_rst) begin
      check("acc",      32'(acc),      32'(m_acc));
      check("ovf",      32'(ovf),      32'(m_ovf));
      check("busy",     32'(busy),     32'(m_run));
      check("in_ready", 32'(in_ready), 32'(m_run));
      check("done",     32'(done),     32'(m_done));
    end
  end

  // Inputs change just after a falling edge and are sampled at the next rising edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1; len = l;
    step();
    start = 1'b0; len = $urandom_range(0, 255);
  endtask

  task automatic accept(input logic [19:0] d);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0; in_data = 20'($urandom);
  endtask

  initial begin
    step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("reset acc", 32'(acc), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset in_ready", 32'(in_ready), 32'h0);

    // rst in the middle of a 4-sample run
    do_start(8'd4);
    accept(20'd11);
    accept(20'd22);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst acc", 32'(acc), 32'h0);
    check("midrst ovf", 32'(ovf), 32'h0);
    check("midrst busy", 32'(busy), 32'h0);
    check("midrst in_ready", 32'(in_ready), 32'h0);
    do_start(8'd1);
    accept(20'd7);
    check("after rst acc", 32'(acc), 32'd7);
    check("after rst done", 32'(done), 32'd1);
    step();

    // 50 + 150
    do_start(8'd2);
    accept(20'd50);
    check("sum2 done early", 32'(done), 32'd0);
    accept(20'd150);
    check("sum2 acc", 32'(acc), 32'd200);
    check("sum2 done", 32'(done), 32'd1);
    step();
    check("sum2 done pulse", 32'(done), 32'd0);
    check("sum2 acc hold", 32'(acc), 32'd200);

    // Positive overflow, sticky through a following zero
    do_start(8'd3);
    accept(20'h7FFFF);
    accept(20'h00001);
    check("ovf set", 32'(ovf), 32'd1);
    accept(20'h00000);
    check("ovf acc", 32'(acc), 32'h80000);
    check("ovf sticky", 32'(ovf), 32'd1);
    step();

    // Negative sample with stalls between samples
    do_start(8'd2);
    accept(20'hFFFFB);
    step(); step(); step();
    check("stall busy", 32'(busy), 32'd1);
    check("stall acc", 32'(acc), 32'hFFFFB);
    accept(20'd3);
    check("neg acc", 32'(acc), 32'hFFFFE);
    check("neg ovf", 32'(ovf), 32'd0);
    check("neg done", 32'(done), 32'd1);
    step();

    // len = 0
    do_start(8'd0);
    check("len0 done", 32'(done), 32'd1);
    check("len0 acc", 32'(acc), 32'd0);
    check("len0 busy", 32'(busy), 32'd0);
    step();

    // start during ACCUM and in DONE is ignored
    do_start(8'd3);
    accept(20'd10);
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    accept(20'd20);
    check("ign start busy", 32'(busy), 32'd1);
    start = 1'b1; len = 8'd5;
    accept(20'd30);
    check("ign start acc", 32'(acc), 32'd60);
    check("ign start done", 32'(done), 32'd1);
    step();
    start = 1'b0;
    check("start in done idle", 32'(busy), 32'd0);

    // start together with in_valid in IDLE: no sample taken
    start = 1'b1; len = 8'd1; in_valid = 1'b1; in_data = 20'd99;
    step();
    start = 1'b0; in_valid = 1'b0;
    check("start+valid acc", 32'(acc), 32'd0);
    check("start+valid busy", 32'(busy), 32'd1);
    accept(20'd5);
    check("start+valid final", 32'(acc), 32'd5);
    step();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      start    = ($urandom_range(0, 7) == 0);
      len      = 8'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 5))
        0:       in_data = 20'h7FFFF;
        1:       in_data = 20'h80000;
        2:       in_data = 20'($urandom_range(0, 15));
        3:       in_data = 20'hFFFFF - 20'($urandom_range(0, 15));
        default: in_data = 20'($urandom);
      endcase
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
